// File: rtl/mastermind_turn_ctrl.sv
// Game-flow controller for the Mastermind machine.
// Chooses the first codemaker from the players' enter buttons. Each round runs clear, then
// code entry, then guesses. The codemaker role rotates across NUM_ROUNDS rounds, and the
// controller keeps a saturating score for each player.
//
// Ports:
//   clk, reset              clock; asynchronous active-low reset
//   enter[NUM_PLAYERS]      per-player enter pulses; only a one-hot value in IDLE starts a game
//   code_done               codemaker committed the secret code (acts in CODE only)
//   guess_done              a guess was compared (acts in GUESS only); guess_correct qualifies it
//   new_game                leave GAME_OVER
//   abort                   return to IDLE from any state; counters are retained
//   active_p / breaker_p    codemaker index; codebreaker = next player (combinational)
//   started, clearRegs, take_code, take_guess, game_over   Moore flags from the state register
//   guess_cnt, round_cnt    guesses in this round; rounds completed
//   scores                  player i score at [i*SCORE_W +: SCORE_W]
module mastermind_turn_ctrl #(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned MAX_GUESSES = 8,
  parameter int unsigned NUM_ROUNDS  = 2,
  parameter int unsigned SCORE_W     = 5,
  localparam int unsigned PW = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1,
  localparam int unsigned GW = $clog2(MAX_GUESSES + 1),
  localparam int unsigned RW = $clog2(NUM_ROUNDS + 1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_PLAYERS-1:0]         enter,
  input  logic                           code_done,
  input  logic                           guess_done,
  input  logic                           guess_correct,
  input  logic                           new_game,
  input  logic                           abort,
  output logic [PW-1:0]                  active_p,
  output logic [PW-1:0]                  breaker_p,
  output logic                           started,
  output logic                           clearRegs,
  output logic                           take_code,
  output logic                           take_guess,
  output logic [GW-1:0]                  guess_cnt,
  output logic [RW-1:0]                  round_cnt,
  output logic                           game_over,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores
);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StCode,
    StGuess,
    StRoundEnd,
    StGameOver
  } state_e;

  state_e                         state_q, state_d;
  logic [PW-1:0]                  active_q, active_d;
  logic [GW-1:0]                  guess_cnt_q, guess_cnt_d;
  logic [RW-1:0]                  round_cnt_q, round_cnt_d;
  logic [NUM_PLAYERS*SCORE_W-1:0] scores_q, scores_d;

  logic                           enter_onehot;
  logic [PW-1:0]                  enter_idx;
  logic [1:0]                     score_inc;

  function automatic logic [PW-1:0] next_player(input logic [PW-1:0] p);
    if (p == PW'(NUM_PLAYERS - 1)) begin
      return '0;
    end
    return p + PW'(1);
  endfunction

  // Saturating add: the extra top bit catches overflow, which clamps to all-ones.
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] s,
                                                 input logic [1:0]         inc);
    logic [SCORE_W:0] sum;
    sum = {1'b0, s} + (SCORE_W + 1)'(inc);
    if (sum[SCORE_W]) begin
      return '1;
    end
    return sum[SCORE_W-1:0];
  endfunction

  // One-hot test: nonzero with a single bit set. Multi-hot or all-zero presses are ignored.
  always_comb begin
    enter_onehot = (enter != '0) && ((enter & (enter - NUM_PLAYERS'(1))) == '0);
    enter_idx    = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (enter[i]) begin
        enter_idx = PW'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    active_d    = active_q;
    guess_cnt_d = guess_cnt_q;
    round_cnt_d = round_cnt_q;
    scores_d    = scores_q;
    score_inc   = 2'd0;

    if (abort) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (enter_onehot) begin
            active_d    = enter_idx;
            scores_d    = '0;
            round_cnt_d = '0;
            state_d     = StClear;
          end
        end
        StClear: begin
          guess_cnt_d = '0;
          state_d     = StCode;
        end
        StCode: begin
          if (code_done) begin
            state_d = StGuess;
          end
        end
        StGuess: begin
          if (guess_done) begin
            guess_cnt_d = guess_cnt_q + GW'(1);
            score_inc   = 2'd1;
            if (guess_correct) begin
              state_d = StRoundEnd;
            end else if (guess_cnt_d == GW'(MAX_GUESSES)) begin
              // Codebreaker ran out of guesses: codemaker earns a bonus point.
              score_inc = 2'd2;
              state_d   = StRoundEnd;
            end
            for (int i = 0; i < NUM_PLAYERS; i++) begin
              if (active_q == PW'(i)) begin
                scores_d[i*SCORE_W +: SCORE_W] = sat_add(scores_q[i*SCORE_W +: SCORE_W],
                                                         score_inc);
              end
            end
          end
        end
        StRoundEnd: begin
          round_cnt_d = round_cnt_q + RW'(1);
          if (round_cnt_d == RW'(NUM_ROUNDS)) begin
            state_d = StGameOver;
          end else begin
            active_d = next_player(active_q);
            state_d  = StClear;
          end
        end
        StGameOver: begin
          if (new_game) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      active_q    <= '0;
      guess_cnt_q <= '0;
      round_cnt_q <= '0;
      scores_q    <= '0;
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      guess_cnt_q <= guess_cnt_d;
      round_cnt_q <= round_cnt_d;
      scores_q    <= scores_d;
    end
  end

  assign active_p   = active_q;
  assign breaker_p  = next_player(active_q);
  assign started    = (state_q != StIdle);
  assign clearRegs  = (state_q == StClear);
  assign take_code  = (state_q == StCode);
  assign take_guess = (state_q == StGuess);
  assign game_over  = (state_q == StGameOver);
  assign guess_cnt  = guess_cnt_q;
  assign round_cnt  = round_cnt_q;
  assign scores     = scores_q;

endmodule

// File: tb/tb_mastermind_turn_ctrl.sv
// Directed bench for mastermind_turn_ctrl.
// Instance a: 2 players, 4 guesses, 2 rounds, 5-bit scores.
// Instance b: 3 players, 3 guesses, 3 rounds, 2-bit scores. It covers wrap-around and saturation.
module tb_mastermind_turn_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Instance a signals
  logic [1:0] a_enter = '0;
  logic a_code_done = 0, a_guess_done = 0, a_guess_correct = 0, a_new_game = 0, a_abort = 0;
  logic [0:0] a_active_p, a_breaker_p;
  logic a_started, a_clear, a_take_code, a_take_guess, a_game_over;
  logic [2:0] a_guess_cnt;
  logic [1:0] a_round_cnt;
  logic [9:0] a_scores;

  // Instance b signals
  logic [2:0] b_enter = '0;
  logic b_code_done = 0, b_guess_done = 0, b_guess_correct = 0, b_new_game = 0, b_abort = 0;
  logic [1:0] b_active_p, b_breaker_p;
  logic b_started, b_clear, b_take_code, b_take_guess, b_game_over;
  logic [1:0] b_guess_cnt;
  logic [1:0] b_round_cnt;
  logic [5:0] b_scores;

  mastermind_turn_ctrl #(
    .NUM_PLAYERS(2), .MAX_GUESSES(4), .NUM_ROUNDS(2), .SCORE_W(5)
  ) u_dut_a (
    .clk(clk), .reset(reset), .enter(a_enter), .code_done(a_code_done),
    .guess_done(a_guess_done), .guess_correct(a_guess_correct), .new_game(a_new_game),
    .abort(a_abort), .active_p(a_active_p), .breaker_p(a_breaker_p), .started(a_started),
    .clearRegs(a_clear), .take_code(a_take_code), .take_guess(a_take_guess),
    .guess_cnt(a_guess_cnt), .round_cnt(a_round_cnt), .game_over(a_game_over),
    .scores(a_scores)
  );

  mastermind_turn_ctrl #(
    .NUM_PLAYERS(3), .MAX_GUESSES(3), .NUM_ROUNDS(3), .SCORE_W(2)
  ) u_dut_b (
    .clk(clk), .reset(reset), .enter(b_enter), .code_done(b_code_done),
    .guess_done(b_guess_done), .guess_correct(b_guess_correct), .new_game(b_new_game),
    .abort(b_abort), .active_p(b_active_p), .breaker_p(b_breaker_p), .started(b_started),
    .clearRegs(b_clear), .take_code(b_take_code), .take_guess(b_take_guess),
    .guess_cnt(b_guess_cnt), .round_cnt(b_round_cnt), .game_over(b_game_over),
    .scores(b_scores)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_guess(input logic correct);
    a_guess_done = 1'b1;
    a_guess_correct = correct;
    tick();
    a_guess_done = 1'b0;
    a_guess_correct = 1'b0;
  endtask

  task automatic b_guess(input logic correct);
    b_guess_done = 1'b1;
    b_guess_correct = correct;
    tick();
    b_guess_done = 1'b0;
    b_guess_correct = 1'b0;
  endtask

  task automatic a_code();
    a_code_done = 1'b1;
    tick();
    a_code_done = 1'b0;
  endtask

  task automatic b_code();
    b_code_done = 1'b1;
    tick();
    b_code_done = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_started", a_started, 0);
    check("rst_active", a_active_p, 0);
    check("rst_scores", a_scores, 0);
    check("rst_flags", {a_clear, a_take_code, a_take_guess, a_game_over}, 0);
    check("rst_b_cnts", {b_guess_cnt, b_round_cnt, b_scores}, 0);
    reset = 1'b1;
    tick();

    // Multi-hot and all-zero enter are ignored
    a_enter = 2'b11;
    tick();
    check("multihot_started", a_started, 0);
    check("multihot_clear", a_clear, 0);
    a_enter = 2'b00;
    tick();
    check("zero_started", a_started, 0);
    check("zero_clear", a_clear, 0);

    // Player 1 starts the game
    a_enter = 2'b10;
    tick();
    a_enter = 2'b00;
    check("start_clear", a_clear, 1);
    check("start_active", a_active_p, 1);
    check("start_breaker", a_breaker_p, 0);
    check("start_started", a_started, 1);
    tick();
    check("code_clear_gone", a_clear, 0);
    check("code_take_code", a_take_code, 1);

    // code_done and guess_done together in CODE: the guess is not counted
    a_code_done = 1'b1;
    a_guess_done = 1'b1;
    tick();
    a_code_done = 1'b0;
    a_guess_done = 1'b0;
    check("same_cyc_take_guess", a_take_guess, 1);
    check("same_cyc_guess_cnt", a_guess_cnt, 0);
    check("same_cyc_score", a_scores, 0);

    // Round 1: three misses, then a hit
    for (int i = 1; i <= 3; i++) begin
      a_guess(1'b0);
      check("r1_miss_cnt", a_guess_cnt, i);
      check("r1_miss_score", a_scores[9:5], i);
      check("r1_still_guess", a_take_guess, 1);
    end
    a_guess(1'b1);
    check("r1_end_cnt", a_guess_cnt, 4);
    check("r1_end_score", a_scores[9:5], 4);
    check("r1_end_flags", {a_take_guess, a_clear, a_started}, 3'b001);
    tick();
    check("r2_clear", a_clear, 1);
    check("r2_active", a_active_p, 0);
    check("r2_breaker", a_breaker_p, 1);
    check("r2_round_cnt", a_round_cnt, 1);
    tick();
    check("r2_guess_cnt_cleared", a_guess_cnt, 0);
    a_code();

    // Round 2: all four guesses miss, so the codemaker gets 1+1+1+2
    for (int i = 0; i < 4; i++) begin
      a_guess(1'b0);
    end
    check("r2_end_cnt", a_guess_cnt, 4);
    check("r2_end_score", a_scores[4:0], 5);
    tick();
    check("go_flag", a_game_over, 1);
    check("go_round_cnt", a_round_cnt, 2);
    check("go_active", a_active_p, 0);
    check("go_scores", a_scores, {5'd4, 5'd5});
    a_guess(1'b0);
    check("go_ignore_guess", a_scores, {5'd4, 5'd5});
    check("go_hold", a_game_over, 1);
    a_new_game = 1'b1;
    tick();
    a_new_game = 1'b0;
    check("ng_idle", a_started, 0);
    check("ng_scores_visible", a_scores, {5'd4, 5'd5});

    // New game clears scores on the way into CLEAR; abort mid-GUESS
    a_enter = 2'b01;
    tick();
    a_enter = 2'b00;
    check("g2_active", a_active_p, 0);
    check("g2_scores_clr", a_scores, 0);
    check("g2_round_clr", a_round_cnt, 0);
    tick();
    a_code();
    a_guess(1'b0);
    check("g2_guess_cnt", a_guess_cnt, 1);
    a_abort = 1'b1;
    tick();
    a_abort = 1'b0;
    check("abort_take_guess", a_take_guess, 0);
    check("abort_started", a_started, 0);
    check("abort_keep_cnt", a_guess_cnt, 1);
    check("abort_keep_score", a_scores[4:0], 1);

    // Instance b: wrap-around of the codemaker and score saturation
    b_enter = 3'b100;
    tick();
    b_enter = 3'b000;
    check("b_active", b_active_p, 2);
    check("b_breaker_wrap", b_breaker_p, 0);
    tick();
    b_code();
    b_guess(1'b0);
    b_guess(1'b0);
    check("b_score_pre_sat", b_scores[5:4], 2);
    b_guess(1'b0);
    check("b_score_sat", b_scores[5:4], 3);
    check("b_guess_cnt_max", b_guess_cnt, 3);
    tick();
    check("b_r2_active_wrap", b_active_p, 0);
    check("b_r2_breaker", b_breaker_p, 1);
    tick();
    b_code();
    b_guess(1'b1);
    tick();
    check("b_r3_active", b_active_p, 1);
    check("b_r3_breaker", b_breaker_p, 2);
    tick();
    b_code();
    b_guess(1'b1);
    tick();
    check("b_go", b_game_over, 1);
    check("b_round_cnt", b_round_cnt, 3);
    check("b_scores", b_scores, 6'b11_01_01);

    // Asynchronous reset mid-CODE takes effect without a clock edge
    a_enter = 2'b10;
    tick();
    a_enter = 2'b00;
    check("g3_scores_clr", a_scores, 0);
    tick();
    check("g3_take_code", a_take_code, 1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_take_code", a_take_code, 0);
    check("arst_take_guess", a_take_guess, 0);
    check("arst_started", a_started, 0);
    check("arst_active", a_active_p, 0);
    check("arst_scores", a_scores, 0);
    check("arst_b_scores", b_scores, 0);
    tick();
    reset = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mastermind_turn_ctrl.md
Name: mastermind_turn_ctrl

Overview:
Parametrised game-flow controller for the Mastermind machine. It selects the first codemaker from NUM_PLAYERS enter buttons and sequences each round: clear, code entry, then guesses. It rotates the codemaker role across NUM_ROUNDS rounds and keeps per-player scores. It sits between the button debouncers and the code/guess register and compare datapath.

Parameters:
NUM_PLAYERS, 2, number of players (2..8); PW = max(1, clog2(NUM_PLAYERS))
MAX_GUESSES, 8, guesses allowed per round (1..15); GW = clog2(MAX_GUESSES+1)
NUM_ROUNDS, 2, rounds per game (1..15); RW = clog2(NUM_ROUNDS+1)
SCORE_W, 5, width of each player's score counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low
enter  in  NUM_PLAYERS  per-player enter button, one-cycle pulses
code_done  in  1  pulse: codemaker has committed the secret code
guess_done  in  1  pulse: codebreaker has submitted a guess and it has been compared
guess_correct  in  1  qualifies guess_done: guess matched the code
new_game  in  1  pulse: leave GAME_OVER
abort  in  1  pulse: return to IDLE from any state
active_p  out  PW  current codemaker index
breaker_p  out  PW  current codebreaker index = (active_p+1) mod NUM_PLAYERS
started  out  1  high in every state except IDLE
clearRegs  out  1  one-cycle clear strobe to datapath registers
take_code  out  1  datapath should load code from active_p
take_guess  out  1  datapath should accept a guess from breaker_p
guess_cnt  out  GW  guesses used in the current round
round_cnt  out  RW  rounds completed
game_over  out  1  high in GAME_OVER
scores  out  NUM_PLAYERS*SCORE_W  player i score at bits [i*SCORE_W +: SCORE_W]

Behaviour:
- Reset (async, active-low): state IDLE; active_p=0, guess_cnt=0, round_cnt=0, scores=0; all strobe/flag outputs 0.
- Flag outputs are Moore-decoded from the registered state: started, clearRegs, take_code, take_guess, game_over. Counters, active_p and scores are registers.
- States:
  - IDLE: wait for enter to be exactly one-hot; all-zero or multi-hot is ignored. On one-hot: active_p<=index, scores<=0, round_cnt<=0, go to CLEAR.
  - CLEAR: clearRegs=1 for exactly one cycle; guess_cnt<=0; next state is CODE unconditionally.
  - CODE: take_code=1. On code_done go to GUESS. Latency: take_guess is asserted the cycle after the code_done pulse.
  - GUESS: take_guess=1. On guess_done: guess_cnt+1 and scores[active_p]+1.
    - If guess_correct: go to ROUND_END.
    - Else if guess_cnt+1 == MAX_GUESSES: add a further +1 to the codemaker (net +2 that cycle) and go to ROUND_END.
    - Else stay in GUESS.
  - ROUND_END: one cycle; round_cnt+1.
    - If round_cnt+1 == NUM_ROUNDS: go to GAME_OVER; active_p is unchanged.
    - Else active_p<=(active_p+1) mod NUM_PLAYERS and go to CLEAR.
  - GAME_OVER: game_over=1; scores, round_cnt and active_p are held. On new_game go to IDLE; scores stay visible until the next game starts.
- abort has highest priority in every state: next state is IDLE. Counters and active_p are retained. Scores are cleared only on the next IDLE->CLEAR transition.
- Inputs outside their state are ignored: enter outside IDLE; code_done outside CODE; guess_done outside GUESS; new_game outside GAME_OVER.
- code_done and guess_done in the same cycle while in CODE: only code_done acts; the guess is not counted.
- Score arithmetic saturates at 2^SCORE_W-1; there is no wrap-around. Saturation applies to each of the +1 and +2 cases.
- Wrap-around: active_p wraps from NUM_PLAYERS-1 to 0, and breaker_p follows. breaker_p is combinational from active_p.
- guess_cnt never exceeds MAX_GUESSES.

Test Plan:
- Reset then enter=2'b10 (N=2) -> CLEAR one cycle with clearRegs=1, active_p=1, breaker_p=0, started=1; then take_code=1.
- In IDLE, enter=2'b11 and enter=2'b00 -> remain in IDLE, started=0, clearRegs never pulses.
- Round with 3 wrong guesses then a correct one (MAX_GUESSES=8) -> guess_cnt=4, codemaker score=4, ROUND_END, next round active_p rotated and clearRegs pulses again.
- MAX_GUESSES=4 with all guesses wrong -> codemaker score=5, round ends after the 4th guess_done; after NUM_ROUNDS=2, game_over=1 and round_cnt=2; new_game -> IDLE.
- SCORE_W=2 with repeated misses -> score sticks at 3. Same-cycle code_done+guess_done in CODE -> guess_cnt stays 0.
- abort mid-GUESS, and async reset asserted mid-CODE -> next cycle (abort) or immediately (reset): IDLE, take_guess and take_code = 0. After reset, scores=0.
